axi_line_mem_slave: RTL and testbench
=====================================

AXI_LINE_MEM_SLAVE -- requirements
Module: axi_line_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter LINE_BYTES, default 64, bytes per line; data width is LINE_BYTES*8.
REQ-003 SHALL have parameter DEPTH, default 256, number of lines stored; power of two.
REQ-004 SHALL have parameter RD_LAT, default 3, AR-handshake-to-rvalid cycles, range 1..15.
REQ-005 SHALL have parameter WR_LAT, default 3, last-of-AW/W-handshake-to-bvalid cycles, range 1..15.
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 reset, asynchronous, active-high.
REQ-007 SHALL have ports: awvalid in 1; awready out 1; awaddr in ADDR_W.
REQ-008 SHALL have ports: wvalid in 1; wready out 1; wdata in LINE_BYTES*8; wstrb in LINE_BYTES byte enables; wlast in 1, ignored.
REQ-009 SHALL have ports: bvalid out 1; bready in 1; bresp out 2.
REQ-010 SHALL have ports: arvalid in 1; arready out 1; araddr in ADDR_W.
REQ-011 SHALL have ports: rvalid out 1; rready in 1; rdata out LINE_BYTES*8; rresp out 2; rlast out 1, equal to rvalid.

Function
REQ-012 SHALL index lines by addr[log2(LINE_BYTES) +: log2(DEPTH)] and ignore the offset bits below it.
REQ-013 SHALL treat an address >= DEPTH*LINE_BYTES as out of range: response SLVERR (2'b10), write dropped, rdata all-zero; in-range response OKAY (2'b00).
REQ-014 SHALL run independent read and write FSMs, each with one transaction outstanding.
REQ-015 Write FSM states SHALL be W_IDLE, W_HAVE_A, W_HAVE_D, W_WAIT and W_RESP.
REQ-016 In W_IDLE, awready and wready SHALL both be 1.
REQ-017 In W_HAVE_A only wready SHALL be 1; in W_HAVE_D only awready SHALL be 1; in W_WAIT and W_RESP neither SHALL be 1.
REQ-018 W_IDLE SHALL go to W_WAIT if AW and W handshake in the same cycle, to W_HAVE_A if only AW handshakes, and to W_HAVE_D if only W handshakes.
REQ-019 W_HAVE_A and W_HAVE_D SHALL go to W_WAIT on the missing handshake.
REQ-020 The write SHALL commit to storage, per wstrb byte, on the edge that completes the AW+W pair.
REQ-021 W_WAIT SHALL count WR_LAT-1 cycles and then go to W_RESP, so bvalid rises exactly WR_LAT cycles after the commit edge.
REQ-022 bvalid and bresp SHALL be held stable until bready; W_RESP SHALL return to W_IDLE on the bvalid&&bready edge.
REQ-023 Read FSM states SHALL be R_IDLE (arready=1), R_WAIT and R_RESP.
REQ-024 The AR handshake SHALL latch the index/error flag and load a counter; rvalid SHALL rise exactly RD_LAT cycles after the AR handshake edge.
REQ-025 rdata SHALL be sampled from storage on the edge rvalid rises and held with rresp until rready; the rvalid&&rready edge SHALL return the FSM to R_IDLE.
REQ-026 When a read sample and a write commit hit the same line on the same edge, the read SHALL return the pre-write data.
REQ-027 wstrb=0 SHALL leave the line unchanged and still produce an OKAY response.
REQ-028 Latency counters SHALL be 4 bits and SHALL NOT wrap; each reloads only on its own handshake.

Reset
REQ-029 On rst, both FSMs SHALL go to idle, counters SHALL be 0, and bvalid, rvalid, rlast, bresp, rresp and rdata SHALL be 0.
REQ-030 While rst is asserted, awready, wready and arready SHALL be 0; they SHALL be 1 from the first cycle after reset release.
REQ-031 Storage SHALL NOT be reset; writes already committed before rst SHALL persist.
REQ-032 A rst mid-transaction SHALL drop the pending response and any uncommitted half of an AW/W pair.

Structure
REQ-033 Package axi_mem_pkg SHALL hold the RESP_OKAY and RESP_SLVERR constants and the write-FSM and read-FSM state enums.
REQ-034 Storage SHALL be a sub-module line_mem_array: DEPTH x LINE_BYTES bytes, one byte-strobed write port, one read port, synchronous.

Verification
REQ-035 AW+W same cycle to 0x1000 with wdata pattern A and full strobe, bready=1 -> bvalid exactly 3 cycles later with bresp=00; then AR 0x1000 -> rvalid 3 cycles later with rdata=A and rlast=1.
REQ-036 W first, AW 4 cycles later to 0x2040, wstrb=0x000F with data 0xDEADBEEF in the low bytes -> read 0x2040 returns 0xDEADBEEF in the low 32 bits with the other bytes unchanged.
REQ-037 AR to 0x0001_0000 (out of range for 256x64) -> rresp=10 and rdata=0; AW/W to the same address -> bresp=10 and storage unchanged.
REQ-038 Hold rready=0 and bready=0 for 5 cycles -> rvalid, bvalid, rdata and bresp stay stable; arready, awready and wready stay 0 until the response is accepted.
REQ-039 Write commit and read sample on the same line on the same edge -> read returns old data; a following read returns new data.
REQ-040 rst pulse during W_WAIT and R_WAIT -> no bvalid or rvalid appears, ready signals return after release, and earlier committed data still reads back.

Source files
------------

// File: rtl/axi_mem_pkg.sv
// Shared response codes and FSM state types for the AXI line-memory slave.
package axi_mem_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      W_IDLE,
      W_HAVE_A,
      W_HAVE_D,
      W_WAIT,
      W_RESP
   } w_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_RESP
   } r_state_t;

endpackage

// File: rtl/line_mem_array.sv
// Line storage: one byte-strobed synchronous write port, one registered read port.
module line_mem_array #(
   parameter int LINE_BYTES = 64,
   parameter int DEPTH      = 256
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wr_en,
   input  logic [$clog2(DEPTH)-1:0]    wr_idx,
   input  logic [LINE_BYTES*8-1:0]     wr_data,
   input  logic [LINE_BYTES-1:0]       wr_strb,
   input  logic                        rd_en,
   input  logic                        rd_clr,
   input  logic [$clog2(DEPTH)-1:0]    rd_idx,
   output logic [LINE_BYTES*8-1:0]     rd_data
);

   logic [LINE_BYTES*8-1:0] mem [DEPTH];

   // Contents are never reset so committed lines survive a reset pulse.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < LINE_BYTES; b++) begin
            if (wr_strb[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
         end
      end
   end

   // A read and a write on the same edge see the pre-write contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= rd_clr ? '0 : mem[rd_idx];
   end

endmodule

// File: rtl/axi_line_mem_slave.sv
// AXI slave serving whole cache lines from local storage with fixed read/write latencies.
module axi_line_mem_slave
   import axi_mem_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int LINE_BYTES = 64,
   parameter int DEPTH      = 256,
   parameter int RD_LAT     = 3,
   parameter int WR_LAT     = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [ADDR_W-1:0]       awaddr,
   input  logic                    wvalid,
   output logic                    wready,
   input  logic [LINE_BYTES*8-1:0] wdata,
   input  logic [LINE_BYTES-1:0]   wstrb,
   input  logic                    wlast,
   output logic                    bvalid,
   input  logic                    bready,
   output logic [1:0]              bresp,
   input  logic                    arvalid,
   output logic                    arready,
   input  logic [ADDR_W-1:0]       araddr,
   output logic                    rvalid,
   input  logic                    rready,
   output logic [LINE_BYTES*8-1:0] rdata,
   output logic [1:0]              rresp,
   output logic                    rlast
);

   localparam int OFF_W  = $clog2(LINE_BYTES);
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int DATA_W = LINE_BYTES*8;
   localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(DEPTH*LINE_BYTES);
   localparam logic [3:0] WR_LOAD = 4'(WR_LAT-1);
   localparam logic [3:0] RD_LOAD = 4'(RD_LAT-1);

   function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
      return {1'b0, addr} >= MEM_BYTES;
   endfunction

   w_state_t            w_state;
   r_state_t            r_state;
   logic [3:0]          w_cnt;
   logic [3:0]          r_cnt;
   logic                aw_hs, w_hs, ar_hs, commit;
   logic [IDX_W-1:0]    aw_idx_p0, ar_idx_p0, cmt_idx;
   logic                aw_err_p0, cmt_err;
   logic [DATA_W-1:0]   w_data_p0, cmt_data;
   logic [LINE_BYTES-1:0] w_strb_p0, cmt_strb;
   logic                unused_bits;

   assign unused_bits = &{1'b0, wlast, awaddr[OFF_W-1:0], araddr[OFF_W-1:0]};

   assign awready = !rst && (w_state == W_IDLE || w_state == W_HAVE_D);
   assign wready  = !rst && (w_state == W_IDLE || w_state == W_HAVE_A);
   assign arready = !rst && (r_state == R_IDLE);
   assign aw_hs   = awvalid && awready;
   assign w_hs    = wvalid && wready;
   assign ar_hs   = arvalid && arready;

   // The pair completes when the missing half arrives; the held half fills the rest.
   assign commit   = (aw_hs || w_state == W_HAVE_A) && (w_hs || w_state == W_HAVE_D);
   assign cmt_idx  = aw_hs ? awaddr[OFF_W +: IDX_W] : aw_idx_p0;
   assign cmt_err  = aw_hs ? out_of_range(awaddr) : aw_err_p0;
   assign cmt_data = w_hs ? wdata : w_data_p0;
   assign cmt_strb = w_hs ? wstrb : w_strb_p0;

   // Stage p0: holding registers for the half of a write pair that arrived first
   always_ff @(posedge clk) begin
      if (aw_hs) begin
         aw_idx_p0 <= awaddr[OFF_W +: IDX_W];
         aw_err_p0 <= out_of_range(awaddr);
      end
      if (w_hs) begin
         w_data_p0 <= wdata;
         w_strb_p0 <= wstrb;
      end
      if (ar_hs) ar_idx_p0 <= araddr[OFF_W +: IDX_W];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state <= W_IDLE;
         w_cnt   <= '0;
         bvalid  <= 1'b0;
         bresp   <= RESP_OKAY;
      end else begin
         case (w_state)
            W_IDLE, W_HAVE_A, W_HAVE_D: begin
               if (commit) begin
                  w_state <= W_WAIT;
                  w_cnt   <= WR_LOAD;
                  bresp   <= cmt_err ? RESP_SLVERR : RESP_OKAY;
               end else if (aw_hs) begin
                  w_state <= W_HAVE_A;
               end else if (w_hs) begin
                  w_state <= W_HAVE_D;
               end
            end
            W_WAIT: begin
               if (w_cnt == '0) begin
                  w_state <= W_RESP;
                  bvalid  <= 1'b1;
               end else begin
                  w_cnt <= w_cnt - 4'd1;
               end
            end
            W_RESP: begin
               if (bready) begin
                  w_state <= W_IDLE;
                  bvalid  <= 1'b0;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // rresp doubles as the latched out-of-range flag for the pending read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= R_IDLE;
         r_cnt   <= '0;
         rvalid  <= 1'b0;
         rresp   <= RESP_OKAY;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ar_hs) begin
                  r_state <= R_WAIT;
                  r_cnt   <= RD_LOAD;
                  rresp   <= out_of_range(araddr) ? RESP_SLVERR : RESP_OKAY;
               end
            end
            R_WAIT: begin
               if (r_cnt == '0) begin
                  r_state <= R_RESP;
                  rvalid  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            R_RESP: begin
               if (rready) begin
                  r_state <= R_IDLE;
                  rvalid  <= 1'b0;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   assign rlast = rvalid;

   line_mem_array #(
      .LINE_BYTES (LINE_BYTES),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (commit && !cmt_err),
      .wr_idx  (cmt_idx),
      .wr_data (cmt_data),
      .wr_strb (cmt_strb),
      .rd_en   (r_state == R_WAIT && r_cnt == '0),
      .rd_clr  (rresp[1]),
      .rd_idx  (ar_idx_p0),
      .rd_data (rdata)
   );

endmodule

// File: tb/tb_axi_line_mem_slave.sv
// Scoreboard bench: drivers push expected responses, a monitor pops and checks them.
module tb_axi_line_mem_slave;

   localparam int ADDR_W = 32;
   localparam int LB     = 64;
   localparam int DW     = LB*8;
   localparam int DEPTH  = 256;
   localparam int RD_LAT = 3;
   localparam int WR_LAT = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              awvalid = 1'b0, awready;
   logic [ADDR_W-1:0] awaddr = '0;
   logic              wvalid = 1'b0, wready;
   logic [DW-1:0]     wdata = '0;
   logic [LB-1:0]     wstrb = '0;
   logic              wlast = 1'b0;
   logic              bvalid, bready = 1'b0;
   logic [1:0]        bresp;
   logic              arvalid = 1'b0, arready;
   logic [ADDR_W-1:0] araddr = '0;
   logic              rvalid, rready = 1'b0;
   logic [DW-1:0]     rdata;
   logic [1:0]        rresp;
   logic              rlast;

   axi_line_mem_slave #(
      .ADDR_W(ADDR_W), .LINE_BYTES(LB), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
   ) dut (
      .clk(clk), .rst(rst),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; int idx; logic [DW-1:0] d; logic [LB-1:0] s; } wr_rec_t;
   typedef struct { bit err; int due; } b_exp_t;
   typedef struct { bit err; int idx; int due; } r_exp_t;

   wr_rec_t hist[$];
   b_exp_t  b_q[$];
   r_exp_t  r_q[$];

   int checks = 0;
   int errors = 0;
   bit hold = 1'b0;
   logic [DW-1:0] last_rdata = '0;
   logic [1:0]    last_rresp = '0;
   logic [DW-1:0] init_d [DEPTH];
   int lines[8] = '{0, 3, 17, 64, 100, 129, 200, 255};

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: got timeout/unexpected, required event", nm);
   endtask

   function automatic bit a_err(input logic [ADDR_W-1:0] a);
      return 64'(a) >= 64'(DEPTH*LB);
   endfunction

   function automatic int a_idx(input logic [ADDR_W-1:0] a);
      return int'((a / LB) % DEPTH);
   endfunction

   // A line's content at an edge is every earlier committed write applied in order.
   function automatic logic [DW-1:0] exp_line(input int idx, input int due);
      logic [DW-1:0] v = '0;
      foreach (hist[i]) begin
         if (hist[i].idx == idx && hist[i].cyc < due) begin
            for (int b = 0; b < LB; b++)
               if (hist[i].s[b]) v[b*8 +: 8] = hist[i].d[b*8 +: 8];
         end
      end
      return v;
   endfunction

   // skew > 0: AW trails W by skew cycles; skew < 0: W trails AW.
   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DW-1:0] d,
                           input logic [LB-1:0] s, input int skew);
      bit aw_done = 1'b0, w_done = 1'b0;
      int k = 0;
      int t_aw = (skew > 0) ? skew : 0;
      int t_w  = (skew < 0) ? -skew : 0;
      while (!(aw_done && w_done) && k < 60) begin
         @(negedge clk);
         awvalid = !aw_done && (k >= t_aw);
         awaddr  = a;
         wvalid  = !w_done && (k >= t_w);
         wdata   = d;
         wstrb   = s;
         wlast   = 1'b1;
         #1;
         if (awvalid && awready) aw_done = 1'b1;
         if (wvalid && wready)   w_done  = 1'b1;
         if (aw_done && w_done) begin
            b_q.push_back('{err: a_err(a), due: cyc + 1 + WR_LAT});
            if (!a_err(a)) hist.push_back('{cyc: cyc + 1, idx: a_idx(a), d: d, s: s});
         end
         k++;
      end
      @(negedge clk);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      if (!(aw_done && w_done)) fail_now("write_handshake");
   endtask

   task automatic do_read(input logic [ADDR_W-1:0] a);
      bit done = 1'b0;
      int k = 0;
      while (!done && k < 60) begin
         @(negedge clk);
         arvalid = 1'b1;
         araddr  = a;
         #1;
         if (arready) begin
            done = 1'b1;
            r_q.push_back('{err: a_err(a), idx: a_idx(a), due: cyc + 1 + RD_LAT});
         end
         k++;
      end
      @(negedge clk);
      arvalid = 1'b0;
      if (!done) fail_now("read_handshake");
   endtask

   task automatic wait_drain(input string nm);
      int k = 0;
      while ((b_q.size() != 0 || r_q.size() != 0 || bvalid || rvalid) && k < 400) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (k >= 400) begin
         errors++;
         $display("FAIL %s: got responses still pending, required drained", nm);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (hold) begin
            bready = 1'b0;
            rready = 1'b0;
         end else begin
            bready = ($urandom_range(0, 3) != 0);
            rready = ($urandom_range(0, 3) != 0);
         end
      end
   end

   bit            b_prev = 1'b0, r_prev = 1'b0;
   logic [1:0]    b_hold, r_hold;
   logic [DW-1:0] rd_hold;

   initial begin
      b_exp_t be;
      r_exp_t re;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            b_prev = 1'b0;
            r_prev = 1'b0;
         end else begin
            if (bvalid && !b_prev) begin
               if (b_q.size() == 0) fail_now("stray_bvalid");
               else begin
                  be = b_q.pop_front();
                  chk("b_latency", DW'(cyc), DW'(be.due));
                  chk("bresp", DW'(bresp), DW'(be.err ? 2'b10 : 2'b00));
               end
               b_hold = bresp;
            end else if (bvalid) begin
               chk("bresp_stable", DW'(bresp), DW'(b_hold));
            end
            if (bvalid) chk("aw_w_ready_in_resp", DW'({awready, wready}), '0);
            b_prev = bvalid;

            if (rvalid && !r_prev) begin
               if (r_q.size() == 0) fail_now("stray_rvalid");
               else begin
                  re = r_q.pop_front();
                  chk("r_latency", DW'(cyc), DW'(re.due));
                  chk("rresp", DW'(rresp), DW'(re.err ? 2'b10 : 2'b00));
                  chk("rdata", rdata, re.err ? '0 : exp_line(re.idx, re.due));
                  chk("rlast", DW'(rlast), DW'(1'b1));
               end
               r_hold     = rresp;
               rd_hold    = rdata;
               last_rdata = rdata;
               last_rresp = rresp;
            end else if (rvalid) begin
               chk("rresp_stable", DW'(rresp), DW'(r_hold));
               chk("rdata_stable", rdata, rd_hold);
            end
            if (rvalid) chk("arready_in_resp", DW'(arready), '0);
            r_prev = rvalid;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DW-1:0] pat_a, dval, nval;
      logic [ADDR_W-1:0] a;
      logic [LB-1:0] s;
      int op, idx;

      // Reset state
      @(negedge clk);
      #1;
      chk("rst_ready", DW'({awready, wready, arready}), '0);
      chk("rst_valid", DW'({bvalid, rvalid, rlast}), '0);
      chk("rst_resp", DW'({bresp, rresp}), '0);
      chk("rst_rdata", rdata, '0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("ready_after_release", DW'({awready, wready, arready}), DW'(3'b111));

      foreach (lines[i]) begin
         for (int w = 0; w < LB/4; w++) init_d[lines[i]][w*32 +: 32] = $urandom;
         do_write(ADDR_W'(lines[i]*LB), init_d[lines[i]], '1, 0);
      end
      wait_drain("init");

      // Same-cycle AW+W then read back
      pat_a = {(LB/4){32'hA5C3_0F1E}};
      do_write(32'h1000, pat_a, '1, 0);
      wait_drain("w_1000");
      do_read(32'h1000);
      wait_drain("r_1000");
      chk("read_1000", last_rdata, pat_a);

      // W first, AW four cycles later, low-word strobe
      dval = '0;
      dval[31:0] = 32'hDEADBEEF;
      s = '0;
      s[3:0] = 4'hF;
      do_write(32'h2040, dval, s, 4);
      wait_drain("w_2040");
      do_read(32'h2040);
      wait_drain("r_2040");
      chk("low32_2040", DW'(last_rdata[31:0]), DW'(32'hDEADBEEF));
      chk("upper_2040", DW'(last_rdata[DW-1:32]), DW'(init_d[129][DW-1:32]));

      // Out-of-range read and write
      do_read(32'h0001_0000);
      wait_drain("r_oor");
      chk("oor_rresp", DW'(last_rresp), DW'(2'b10));
      chk("oor_rdata", last_rdata, '0);
      do_write(32'h0001_0000, {(LB/4){32'h1234_5678}}, '1, -2);
      wait_drain("w_oor");
      do_read(32'h0000_0000);
      wait_drain("r_line0");
      chk("line0_untouched", last_rdata, init_d[0]);

      // Read sample and write commit on the same line on the same edge
      nval = {(LB/4){32'h0BAD_F00D}};
      fork
         do_read(32'h0000_0448);
         begin
            repeat (RD_LAT) @(negedge clk);
            do_write(32'h0000_0440, nval, '1, 0);
         end
      join
      wait_drain("same_edge");
      chk("same_edge_old", last_rdata, init_d[17]);
      do_read(32'h0000_0440);
      wait_drain("after_same_edge");
      chk("after_same_edge_new", last_rdata, nval);

      // Back-pressure: responses held with ready low
      hold = 1'b1;
      fork
         do_write(ADDR_W'(200*LB), {(LB/4){32'hCAFE_0001}}, '1, 0);
         do_read(ADDR_W'(255*LB + 5));
      join
      repeat (RD_LAT + 6) @(negedge clk);
      #1;
      chk("held_valids", DW'({bvalid, rvalid}), DW'(2'b11));
      hold = 1'b0;
      wait_drain("hold");

      // Reset while both FSMs wait on latency
      nval = {(LB/4){32'h7777_3333}};
      fork
         do_write(ADDR_W'(3*LB), nval, '1, 0);
         do_read(ADDR_W'(100*LB));
      join
      rst = 1'b1;
      b_q.delete();
      r_q.delete();
      #1;
      chk("mid_rst_ready", DW'({awready, wready, arready}), '0);
      repeat (2) @(negedge clk);
      #1;
      chk("mid_rst_valid", DW'({bvalid, rvalid}), '0);
      chk("mid_rst_rdata", rdata, '0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("ready_after_mid_rst", DW'({awready, wready, arready}), DW'(3'b111));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         chk("no_resp_after_rst", DW'({bvalid, rvalid}), '0);
      end
      do_read(ADDR_W'(3*LB));
      wait_drain("r_after_rst");
      chk("committed_before_rst", last_rdata, nval);
      do_read(32'h1000);
      wait_drain("r_1000_after_rst");
      chk("persist_1000", last_rdata, pat_a);

      // Randomized traffic
      for (int n = 0; n < 150; n++) begin
         op  = $urandom_range(0, 9);
         idx = lines[$urandom_range(0, 7)];
         a   = ADDR_W'(idx*LB + $urandom_range(0, LB-1));
         if (op == 9) a = ADDR_W'($urandom_range(32'hFFFF_FFFF, 32'h0000_4000));
         if (op < 5 || (op == 9 && $urandom_range(0, 1) == 0)) begin
            for (int w = 0; w < LB/4; w++) dval[w*32 +: 32] = $urandom;
            case ($urandom_range(0, 3))
               0:       s = '0;
               1:       s = '1;
               default: for (int w = 0; w < LB/32; w++) s[w*32 +: 32] = $urandom;
            endcase
            do_write(a, dval, s, $urandom_range(0, 6) - 3);
         end else begin
            do_read(a);
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_drain("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
